// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, memory-wait/timeout and branch-flush sequencing with EXE forwarding
// Optional feature macro: HAZARD_PERF_CNT_EN (performance counters).
module pipe_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] src1_id,
    input  logic [REG_W-1:0] src2_id,
    input  logic             two_src_id,
    input  logic [REG_W-1:0] exe_dest,
    input  logic [REG_W-1:0] mem_dest,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             wb_wb_en,
    input  logic             exe_mem_r_en,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             freeze_front,
    output logic             clr_id_exe,
    output logic             flush_if_id,
    output logic             freeze_back,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_FLUSH,
        ST_TIMEOUT_REL
    } state_t;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam bit         LONG_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [2:0]       fl_cnt_q, fl_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [REG_W-1:0] src1_exe_q, src1_exe_d;
    logic [REG_W-1:0] src2_exe_q, src2_exe_d;
    logic             v1_exe_q, v1_exe_d;
    logic             v2_exe_q, v2_exe_d;

    logic       haz1, haz2, hazard;
    logic       mem_stall, flush_active;
    logic       fb_raw, ff_raw, fl_raw, clr_raw;
    logic [1:0] sel1_raw, sel2_raw;

    always_comb begin
        if (forward_en) begin
            haz1 = exe_mem_r_en & exe_wb_en & (exe_dest == src1_id);
            haz2 = exe_mem_r_en & exe_wb_en & (exe_dest == src2_id);
        end else begin
            haz1 = (exe_wb_en & (exe_dest == src1_id)) | (mem_wb_en & (mem_dest == src1_id));
            haz2 = (exe_wb_en & (exe_dest == src2_id)) | (mem_wb_en & (mem_dest == src2_id));
        end
        hazard = haz1 | (haz2 & two_src_id);
    end

    // The release cycle after a timeout must not re-stall even if memory is still busy.
    assign mem_stall    = mem_access & ~mem_ready & (state_q != ST_TIMEOUT_REL);
    assign flush_active = branch_taken | (state_q == ST_FLUSH);

    assign fb_raw  = mem_stall;
    assign ff_raw  = mem_stall | (hazard & ~flush_active);
    assign fl_raw  = flush_active & ~mem_stall;
    assign clr_raw = ~mem_stall & (flush_active | hazard);

    always_comb begin
        sel1_raw = 2'b00;
        sel2_raw = 2'b00;
        if (forward_en & v1_exe_q & mem_wb_en & (mem_dest == src1_exe_q)) begin
            sel1_raw = 2'b01;
        end else if (forward_en & v1_exe_q & wb_wb_en & (wb_dest == src1_exe_q)) begin
            sel1_raw = 2'b10;
        end
        if (forward_en & v2_exe_q & mem_wb_en & (mem_dest == src2_exe_q)) begin
            sel2_raw = 2'b01;
        end else if (forward_en & v2_exe_q & wb_wb_en & (wb_dest == src2_exe_q)) begin
            sel2_raw = 2'b10;
        end
    end

    assign freeze_back  = rst & fb_raw;
    assign freeze_front = rst & ff_raw;
    assign flush_if_id  = rst & fl_raw;
    assign clr_id_exe   = rst & clr_raw;
    assign sel_src1     = rst ? sel1_raw : 2'b00;
    assign sel_src2     = rst ? sel2_raw : 2'b00;
    assign mem_err      = mem_err_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN, ST_TIMEOUT_REL: begin
                if (mem_stall) begin
                    wait_cnt_d = 8'd0;
                    if (TIMEOUT_LIM <= 9'd1) begin
                        state_d   = ST_TIMEOUT_REL;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d = ST_MEMWAIT;
                    end
                end else if (branch_taken && LONG_FLUSH) begin
                    state_d  = ST_FLUSH;
                    fl_cnt_d = FLUSH_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (!mem_stall) begin
                    if (branch_taken && LONG_FLUSH) begin
                        state_d  = ST_FLUSH;
                        fl_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                // wait_cnt counts MEMWAIT cycles; +2 adds the entry cycle and this one.
                end else if (({1'b0, wait_cnt_q} + 9'd2) >= TIMEOUT_LIM) begin
                    state_d   = ST_TIMEOUT_REL;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                if (!mem_stall) begin
                    if (branch_taken && LONG_FLUSH) begin
                        fl_cnt_d = FLUSH_LOAD;
                    end else if (fl_cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        fl_cnt_d = fl_cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        src1_exe_d = src1_exe_q;
        src2_exe_d = src2_exe_q;
        v1_exe_d   = v1_exe_q;
        v2_exe_d   = v2_exe_q;
        if (!fb_raw) begin
            src1_exe_d = src1_id;
            src2_exe_d = src2_id;
            v1_exe_d   = ~clr_raw;
            v2_exe_d   = two_src_id & ~clr_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            fl_cnt_q   <= 3'd0;
            mem_err_q  <= 1'b0;
            src1_exe_q <= '0;
            src2_exe_q <= '0;
            v1_exe_q   <= 1'b0;
            v2_exe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
            mem_err_q  <= mem_err_d;
            src1_exe_q <= src1_exe_d;
            src2_exe_q <= src2_exe_d;
            v1_exe_q   <= v1_exe_d;
            v2_exe_q   <= v2_exe_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;
    logic             branch_prev_q, branch_prev_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        branch_prev_d = branch_taken;
        if (ff_raw && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_taken && !branch_prev_q && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (mem_stall && (memwait_cnt_q != '1)) begin
            memwait_cnt_d = memwait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
            branch_prev_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
            branch_prev_q <= branch_prev_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`else
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        forward_en;
    logic [3:0]  src1_id, src2_id;
    logic        two_src_id;
    logic [3:0]  exe_dest, mem_dest, wb_dest;
    logic        exe_wb_en, mem_wb_en, wb_wb_en;
    logic        exe_mem_r_en, mem_access, mem_ready, branch_taken;
    logic        freeze_front, clr_id_exe, flush_if_id, freeze_back;
    logic [1:0]  sel_src1, sel_src2;
    logic        mem_err;
    logic [15:0] stall_cnt, flush_cnt, memwait_cnt;

    int total  = 0;
    int passed = 0;

    pipe_hazard_ctrl #(
        .REG_W(4), .FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .src1_id(src1_id), .src2_id(src2_id), .two_src_id(two_src_id),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_access(mem_access), .mem_ready(mem_ready),
        .branch_taken(branch_taken),
        .freeze_front(freeze_front), .clr_id_exe(clr_id_exe), .flush_if_id(flush_if_id),
        .freeze_back(freeze_back), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        forward_en = 0; src1_id = 0; src2_id = 0; two_src_id = 0;
        exe_dest = 0; mem_dest = 0; wb_dest = 0;
        exe_wb_en = 0; mem_wb_en = 0; wb_wb_en = 0;
        exe_mem_r_en = 0; mem_access = 0; mem_ready = 0; branch_taken = 0;
    endtask

    // ctl packs {freeze_front, clr_id_exe, flush_if_id, freeze_back}
    function automatic logic [3:0] ctl();
        return {freeze_front, clr_id_exe, flush_if_id, freeze_back};
    endfunction

    initial begin
        clear_inputs();
        rst = 0;
        tick();
        tick();
        branch_taken = 1; mem_access = 1; #1;
        chk("in_reset_ctl", ctl(), 4'b0000);
        chk("in_reset_sel1", sel_src1, 2'b00);
        clear_inputs();
        rst = 1;
        tick();
        chk("reset_ctl", ctl(), 4'b0000);
        chk("reset_mem_err", mem_err, 1'b0);
        chk("reset_stall_cnt", stall_cnt, 16'd0);

        // load-use with forwarding
        forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; src1_id = 3; #1;
        chk("loaduse_ctl", ctl(), 4'b1100);
        tick();
        exe_mem_r_en = 0; exe_wb_en = 0; mem_wb_en = 1; mem_dest = 3; #1;
        chk("loaduse_release", ctl(), 4'b0000);
        chk("loaduse_bubble_sel1", sel_src1, 2'b00);
        tick();
        chk("loaduse_fwd_sel1", sel_src1, 2'b01);

        // no forwarding: src2 only counts when two_src_id
        clear_inputs();
        mem_wb_en = 1; mem_dest = 5; src2_id = 5; two_src_id = 0; #1;
        chk("nofwd_one_src", ctl(), 4'b0000);
        two_src_id = 1; #1;
        chk("nofwd_two_src", ctl(), 4'b1100);
        chk("nofwd_sel2", sel_src2, 2'b00);
        tick();

        // forwarding priority MEM over WB
        clear_inputs();
        forward_en = 1; src1_id = 2; src2_id = 2; two_src_id = 0;
        tick();
        mem_dest = 2; wb_dest = 2; mem_wb_en = 1; wb_wb_en = 1; #1;
        chk("prio_mem_sel1", sel_src1, 2'b01);
        chk("prio_v2_invalid_sel2", sel_src2, 2'b00);
        mem_wb_en = 0; #1;
        chk("prio_wb_sel1", sel_src1, 2'b10);
        forward_en = 0; #1;
        chk("prio_fwd_off_sel1", sel_src1, 2'b00);

        // memory wait, released by mem_ready
        clear_inputs();
        tick();
        mem_access = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("memwait_c%0d", i), ctl(), 4'b1001);
            tick();
        end
        mem_ready = 1; #1;
        chk("memwait_release", ctl(), 4'b0000);
        tick();
        chk("memwait_cnt", memwait_cnt, PERF ? 32'd3 : 32'd0);
        chk("stall_cnt_a", stall_cnt, PERF ? 32'd5 : 32'd0);
        chk("memwait_no_err", mem_err, 1'b0);

        // timeout after 4 wait cycles
        clear_inputs();
        mem_access = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("timeout_wait_c%0d", i), freeze_back, 1'b1);
            tick();
        end
        chk("timeout_err", mem_err, 1'b1);
        chk("timeout_release", ctl(), 4'b0000);
        tick();
        chk("timeout_restall", freeze_back, 1'b1);
        mem_access = 0; #1;
        chk("memwait_cnt_b", memwait_cnt, PERF ? 32'd7 : 32'd0);
        chk("stall_cnt_b", stall_cnt, PERF ? 32'd9 : 32'd0);
        tick();
        chk("err_sticky", mem_err, 1'b1);

        // branch flush of three cycles
        clear_inputs();
        branch_taken = 1; #1;
        chk("branch_c0", ctl(), 4'b0110);
        tick();
        branch_taken = 0; #1;
        chk("branch_c1", ctl(), 4'b0110);
        tick();
        chk("branch_c2", ctl(), 4'b0110);
        tick();
        chk("branch_done", ctl(), 4'b0000);
        chk("flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);

        // reset in the middle of a flush
        branch_taken = 1;
        tick();
        branch_taken = 0; #1;
        chk("branch2_c1", ctl(), 4'b0110);
        rst = 0; #1;
        chk("rst_mid_flush_ctl", ctl(), 4'b0000);
        tick();
        rst = 1; #1;
        chk("after_rst_ctl", ctl(), 4'b0000);
        chk("after_rst_err", mem_err, 1'b0);
        chk("after_rst_flush_cnt", flush_cnt, 16'd0);
        tick();
        chk("after_rst_no_pending", ctl(), 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
